// File: rtl/rbt_s_pkg.sv
// Shared constants for the rbt_s header path: metadata field positions and tag indices.
// No logic; latency n/a.
// Helper rr_next gives the wrap-around successor used by the round-robin pointers.
package rbt_s_pkg;

  localparam int PKT_OP_NO               = 232;
  localparam int PKT_PROPERTY_NO         = 246;
  localparam int DAT_TAG_INDEX           = 0;
  localparam int NACK_TAG_INDEX          = 1;
  localparam int LOCAL_TAG_INDEX         = 3;
  localparam int TX_TABLE_MASK_TAG_INDEX = 7;
  localparam int PKT_META_W              = 272;

  // Metadata bit that marks a header as NACK-class.
  localparam int NACK_BIT = PKT_PROPERTY_NO + NACK_TAG_INDEX;

  // Successor of a port index, wrapping (n-1) back to 0.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    rr_next = (int'(idx) >= n - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rbt_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the pick is used.
module rbt_rr_pick #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [2:0]           idx,
  output logic                 any
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IW-1:0] w_pos;
  logic          w_found;

  assign any = |req;

  // Scan ports starting at ptr and grant the first requester found.
  always_comb begin
    gnt     = '0;
    idx     = 3'd0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int p;
      p = int'(ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      w_pos = IW'(p);
      if (!w_found && req[w_pos]) begin
        w_found    = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = 3'(p);
      end
    end
  end

endmodule

// File: rtl/rbt_s_hdr_arb.sv
// Two-class (NACK over normal) round-robin arbiter of parsed headers onto one registered bus.
// Latency 1 cycle input transfer -> output valid; 1 header/cycle with ready held high.
// Downstream stall freezes outputs, pointers and starvation counter, and drops all input readies.
module rbt_s_hdr_arb
  import rbt_s_pkg::*;
#(
  parameter int NUM_PORTS          = 4,
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = 272,
  parameter int STARVE_LIMIT       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    in_proto_hdr_valid,
  output logic [NUM_PORTS-1:0]                    in_proto_hdr_ready,
  input  logic [16*NUM_PORTS-1:0]                 in_proto_hdr_length,
  input  logic [PKT_METADATA_WIDTH*NUM_PORTS-1:0] in_proto_hdr_pkt_metadata,
  input  logic [HEADER_WIDTH*NUM_PORTS-1:0]       in_proto_hdr_data,
  output logic                                    out_proto_hdr_valid,
  input  logic                                    out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0]                 out_proto_hdr_data,
  output logic [PKT_METADATA_WIDTH-1:0]           out_proto_hdr_pkt_metadata,
  output logic [15:0]                             out_proto_hdr_length,
  output logic [2:0]                              out_src_port
);

  localparam int HW = HEADER_WIDTH;
  localparam int MW = PKT_METADATA_WIDTH;

  logic                 r_vld;
  logic [HW-1:0]        r_data;
  logic [MW-1:0]        r_meta;
  logic [15:0]          r_len;
  logic [2:0]           r_src;
  logic [2:0]           r_nack_ptr;
  logic [2:0]           r_norm_ptr;
  logic [7:0]           r_starve_cnt;

  logic [NUM_PORTS-1:0] w_nack_req;
  logic [NUM_PORTS-1:0] w_norm_req;
  logic [NUM_PORTS-1:0] w_nack_gnt;
  logic [NUM_PORTS-1:0] w_norm_gnt;
  logic [2:0]           w_nack_idx;
  logic [2:0]           w_norm_idx;
  logic                 w_nack_any;
  logic                 w_norm_any;
  logic                 w_can_load;
  logic                 w_force_norm;
  logic                 w_sel_norm;
  logic                 w_xfer;
  logic [2:0]           w_gnt_idx;
  logic [7:0]           w_starve_inc;

  // Split valid requests into NACK-class and normal-class by the metadata tag bit.
  always_comb begin
    w_nack_req = '0;
    w_norm_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_nack_req[i] = in_proto_hdr_valid[i] &  in_proto_hdr_pkt_metadata[i*MW + NACK_BIT];
      w_norm_req[i] = in_proto_hdr_valid[i] & ~in_proto_hdr_pkt_metadata[i*MW + NACK_BIT];
    end
  end

  rbt_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_nack (
    .req (w_nack_req),
    .ptr (r_nack_ptr),
    .gnt (w_nack_gnt),
    .idx (w_nack_idx),
    .any (w_nack_any)
  );

  rbt_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_norm (
    .req (w_norm_req),
    .ptr (r_norm_ptr),
    .gnt (w_norm_gnt),
    .idx (w_norm_idx),
    .any (w_norm_any)
  );

  // The output register can take a header when empty or being drained this cycle.
  assign w_can_load   = !r_vld || out_proto_hdr_ready;
  // Normal traffic wins once too many NACK grants went by while it waited.
  assign w_force_norm = (r_starve_cnt >= 8'(STARVE_LIMIT)) && w_norm_any;
  assign w_sel_norm   = w_force_norm || (!w_nack_any && w_norm_any);
  assign w_xfer       = w_can_load && (w_nack_any || w_norm_any);
  assign w_gnt_idx    = w_sel_norm ? w_norm_idx : w_nack_idx;
  assign w_starve_inc = (r_starve_cnt >= 8'(STARVE_LIMIT)) ? 8'(STARVE_LIMIT) : r_starve_cnt + 8'd1;

  // Readies go only to the picked (hence valid) port, so a ready always completes a transfer.
  assign in_proto_hdr_ready = w_can_load ? (w_sel_norm ? w_norm_gnt : w_nack_gnt) : '0;

  // Output stage, round-robin pointers and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld        <= 1'b0;
      r_data       <= '0;
      r_meta       <= '0;
      r_len        <= '0;
      r_src        <= '0;
      r_nack_ptr   <= '0;
      r_norm_ptr   <= '0;
      r_starve_cnt <= '0;
    end else if (w_xfer) begin
      r_vld  <= 1'b1;
      r_data <= in_proto_hdr_data[int'(w_gnt_idx)*HW +: HW];
      r_meta <= in_proto_hdr_pkt_metadata[int'(w_gnt_idx)*MW +: MW];
      r_len  <= in_proto_hdr_length[int'(w_gnt_idx)*16 +: 16];
      r_src  <= w_gnt_idx;
      if (w_sel_norm) begin
        r_norm_ptr   <= rr_next(w_gnt_idx, NUM_PORTS);
        r_starve_cnt <= 8'd0;
      end else begin
        r_nack_ptr   <= rr_next(w_gnt_idx, NUM_PORTS);
        r_starve_cnt <= w_norm_any ? w_starve_inc : 8'd0;
      end
    end else if (r_vld && out_proto_hdr_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign out_proto_hdr_valid        = r_vld;
  assign out_proto_hdr_data         = r_data;
  assign out_proto_hdr_pkt_metadata = r_meta;
  assign out_proto_hdr_length       = r_len;
  assign out_src_port               = r_src;

endmodule

// File: tb/tb_rbt_s_hdr_arb.sv
// Directed bench for rbt_s_hdr_arb: vector table for single-port, round-robin and priority,
// then hand sequences for starvation, back-pressure and asynchronous reset mid-operation.
// DUT built with 4 ports, 64-bit headers, 272-bit metadata, STARVE_LIMIT=3.
module tb_rbt_s_hdr_arb;

  localparam int NP = 4;
  localparam int HW = 64;
  localparam int MW = 272;
  localparam int SL = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [16*NP-1:0]  in_len;
  logic [MW*NP-1:0]  in_meta;
  logic [HW*NP-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [HW-1:0]     out_data;
  logic [MW-1:0]     out_meta;
  logic [15:0]       out_len;
  logic [2:0]        out_src;

  int n_tests = 0;
  int n_fail  = 0;

  rbt_s_hdr_arb #(
    .NUM_PORTS(NP), .HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW), .STARVE_LIMIT(SL)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .in_proto_hdr_valid         (in_valid),
    .in_proto_hdr_ready         (in_ready),
    .in_proto_hdr_length        (in_len),
    .in_proto_hdr_pkt_metadata  (in_meta),
    .in_proto_hdr_data          (in_data),
    .out_proto_hdr_valid        (out_valid),
    .out_proto_hdr_ready        (out_ready),
    .out_proto_hdr_data         (out_data),
    .out_proto_hdr_pkt_metadata (out_meta),
    .out_proto_hdr_length       (out_len),
    .out_src_port               (out_src)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] exp_data(input int p);
    exp_data = {32'hC0DE0000 + 32'(p), 32'h5A5A0000 + 32'(p * 17)};
  endfunction

  function automatic logic [MW-1:0] exp_meta(input int p, input logic nk);
    logic [MW-1:0] m;
    m = '0;
    for (int b = 0; b < MW / 8; b++) m[8*b +: 8] = 8'(8'h30 + p + b);
    m[247] = nk;
    exp_meta = m;
  endfunction

  function automatic logic [15:0] exp_len(input int p);
    exp_len = 16'(p * 32);
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [NP-1:0] vld, input logic [NP-1:0] nk, input logic ordy);
    for (int p = 0; p < NP; p++) begin
      in_data[p*HW +: HW] = exp_data(p);
      in_meta[p*MW +: MW] = exp_meta(p, nk[p]);
      in_len[p*16 +: 16]  = exp_len(p);
    end
    in_valid  = vld;
    out_ready = ordy;
  endtask

  // Apply one cycle of inputs, check readies mid-cycle and the registered outputs after the edge.
  task automatic step(input string nm, input logic [NP-1:0] vld, input logic [NP-1:0] nk,
                      input logic ordy, input logic [NP-1:0] erdy, input logic eovld,
                      input logic [2:0] esrc);
    drive(vld, nk, ordy);
    @(negedge clk);
    chk({nm, " in_ready"}, MW'(in_ready), MW'(erdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, MW'(out_valid), MW'(eovld));
    if (eovld) begin
      chk({nm, " out_src"},  MW'(out_src),  MW'(esrc));
      chk({nm, " out_data"}, MW'(out_data), MW'(exp_data(int'(esrc))));
      chk({nm, " out_len"},  MW'(out_len),  MW'(exp_len(int'(esrc))));
      chk({nm, " out_meta"}, out_meta, exp_meta(int'(esrc), nk[esrc]));
    end
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset out_valid", MW'(out_valid), '0);
    chk("reset out_src",   MW'(out_src),   '0);
    chk("reset out_data",  MW'(out_data),  '0);
    chk("reset out_len",   MW'(out_len),   '0);
    chk("reset out_meta",  out_meta,       '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            rst;
    logic [NP-1:0] vld;
    logic [NP-1:0] nk;
    logic          ordy;
    logic [NP-1:0] rdy;
    logic          ovld;
    logic [2:0]    src;
  } vec_t;

  vec_t tbl[16];
  int   n_vec = 0;

  task automatic add(input bit r, input logic [NP-1:0] v, input logic [NP-1:0] k,
                     input logic o, input logic [NP-1:0] rd, input logic ov, input logic [2:0] s);
    tbl[n_vec] = '{rst: r, vld: v, nk: k, ordy: o, rdy: rd, ovld: ov, src: s};
    n_vec++;
  endtask

  int order[8] = '{0, 1, 0, 2, 1, 0, 1, 2};

  initial begin
    drive('0, '0, 1'b0);
    #3;

    // Single port 2, length 0x40: ready for exactly one cycle, output next cycle.
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd0);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 3'd2);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd0);
    // All four normal, continuously valid: 0,1,2,3,0,1 with no bubbles.
    add(1, 4'b1111, 4'b0000, 1, 4'b0001, 1, 3'd0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 3'd1);
    add(0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 3'd2);
    add(0, 4'b1111, 4'b0000, 1, 4'b1000, 1, 3'd3);
    add(0, 4'b1111, 4'b0000, 1, 4'b0001, 1, 3'd0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 3'd1);
    // Port 3 NACK beats normal ports 0-2, which then follow in order.
    add(1, 4'b1111, 4'b1000, 1, 4'b1000, 1, 3'd3);
    add(0, 4'b0111, 4'b0000, 1, 4'b0001, 1, 3'd0);
    add(0, 4'b0111, 4'b0000, 1, 4'b0010, 1, 3'd1);
    add(0, 4'b0111, 4'b0000, 1, 4'b0100, 1, 3'd2);

    for (int i = 0; i < n_vec; i++) begin
      if (tbl[i].rst) do_reset();
      step($sformatf("vec%0d", i), tbl[i].vld, tbl[i].nk, tbl[i].ordy,
           tbl[i].rdy, tbl[i].ovld, tbl[i].src);
    end

    // Starvation guard: NACK ports 0,1 and normal port 2 -> 0,1,0,2,1,0,1,2.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step($sformatf("starve%0d", k), 4'b0111, 4'b0011, 1'b1,
           4'(1 << order[k]), 1'b1, 3'(order[k]));
      if (k == 2) chk("starve cnt at limit", MW'(dut.r_starve_cnt), MW'(SL));
      if (order[k] == 2) chk($sformatf("starve cnt clear%0d", k), MW'(dut.r_starve_cnt), '0);
    end

    // Back-pressure: five stalled cycles hold everything, release loads next with no bubble.
    do_reset();
    step("bp load", 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 3'd0);
    for (int k = 0; k < 5; k++) begin
      step($sformatf("bp stall%0d", k), 4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd0);
      chk($sformatf("bp norm_ptr%0d", k), MW'(dut.r_norm_ptr), MW'(1));
      chk($sformatf("bp nack_ptr%0d", k), MW'(dut.r_nack_ptr), MW'(0));
    end
    step("bp release", 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 3'd1);
    chk("bp norm_ptr after", MW'(dut.r_norm_ptr), MW'(2));

    // Asynchronous reset between edges while output is valid.
    do_reset();
    step("mid0", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 3'd0);
    step("mid1", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", MW'(out_valid), '0);
    chk("mid rst norm_ptr",  MW'(dut.r_norm_ptr), '0);
    chk("mid rst out_src",   MW'(out_src), '0);
    drive('0, '0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post rst", 4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1, 3'd1);
    step("post rst2", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 3'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
